obi_apb_bridge_mp: RTL and testbench



---
 rtl/obi_apb_pkg.sv | 26 ++
 rtl/obi_apb_addr_decode.sv | 44 ++++
 rtl/obi_apb_bridge_mp.sv | 192 +++++++++++++++++++
 tb/tb_obi_apb_bridge_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/obi_apb_pkg.sv
// Shared types and constants for the multi-port OBI-to-APB bridge.
// Contents:
//   state_e      - bridge FSM state encoding
//   addr_rule_t  - one address-decode rule {base, mask}
//   PprotDefault - default constant PPROT value
package obi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Rules are stored at a fixed width so the struct can live in the package;
  // narrower address maps are zero-extended into it.
  localparam int unsigned RuleAddrWidth = 64;

  typedef struct packed {
    logic [RuleAddrWidth-1:0] base;
    logic [RuleAddrWidth-1:0] mask;
  } addr_rule_t;

  localparam logic [2:0] PprotDefault = 3'b010;

endpackage

// File: rtl/obi_apb_addr_decode.sv
// Combinational address decoder for the OBI-to-APB bridge.
// Port i hits when (addr & AddrMask[i]) == BaseAddr[i]; all rules are
// compared in parallel and the lowest hitting index wins.
// Ports:
//   addr_i - address to decode
//   idx_o  - index of the selected port (0 when no hit)
//   hit_o  - at least one port matched
module obi_apb_addr_decode
  import obi_apb_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned IdxWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  parameter logic [NumPorts-1:0][AddrWidth-1:0] BaseAddr = '0,
  parameter logic [NumPorts-1:0][AddrWidth-1:0] AddrMask = '0
) (
  input  logic [AddrWidth-1:0] addr_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 hit_o
);

  addr_rule_t [NumPorts-1:0] rules;
  logic       [NumPorts-1:0] match;

  for (genvar i = 0; i < NumPorts; i++) begin : g_rule
    assign rules[i].base = RuleAddrWidth'(BaseAddr[i]);
    assign rules[i].mask = RuleAddrWidth'(AddrMask[i]);
    assign match[i] = ((RuleAddrWidth'(addr_i) & rules[i].mask) == rules[i].base);
  end

  // Walking from the top down lets the lowest matching index overwrite
  // any higher one, giving lowest-index priority on overlapping regions.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o = 1'b1;
        idx_o = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/obi_apb_bridge_mp.sv
// Multi-port OBI-to-APB bridge. Accepts one OBI transaction at a time,
// decodes it onto one of NumPorts APB subordinates and runs a SETUP/ACCESS
// transfer there. The response is returned as a one-cycle registered
// rvalid. Decode misses and ACCESS phases longer than TimeoutCycles
// complete with an OBI error.
// Ports:
//   clk_i, rst_i                  - clock, synchronous active-high reset
//   obi_req_i/obi_gnt_o           - OBI request handshake
//   obi_addr_i/we_i/be_i/wdata_i  - OBI request payload
//   obi_rvalid_o/rdata_o/err_o    - OBI response
//   apb_paddr_o..apb_penable_o    - APB request, psel one-hot per port
//   apb_prdata_i/pready_i/pslverr_i - per-port APB response
module obi_apb_bridge_mp
  import obi_apb_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumPorts      = 4,
  parameter logic [NumPorts-1:0][AddrWidth-1:0] BaseAddr = '0,
  parameter logic [NumPorts-1:0][AddrWidth-1:0] AddrMask = '0,
  parameter int unsigned TimeoutCycles = 16,
  parameter logic [2:0]  Pprot         = PprotDefault,
  localparam int unsigned BeWidth      = DataWidth / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                obi_req_i,
  output logic                                obi_gnt_o,
  input  logic [AddrWidth-1:0]                obi_addr_i,
  input  logic                                obi_we_i,
  input  logic [BeWidth-1:0]                  obi_be_i,
  input  logic [DataWidth-1:0]                obi_wdata_i,
  output logic                                obi_rvalid_o,
  output logic [DataWidth-1:0]                obi_rdata_o,
  output logic                                obi_err_o,
  output logic [AddrWidth-1:0]                apb_paddr_o,
  output logic                                apb_pwrite_o,
  output logic [DataWidth-1:0]                apb_pwdata_o,
  output logic [BeWidth-1:0]                  apb_pstrb_o,
  output logic [2:0]                          apb_pprot_o,
  output logic [NumPorts-1:0]                 apb_psel_o,
  output logic                                apb_penable_o,
  input  logic [NumPorts-1:0][DataWidth-1:0]  apb_prdata_i,
  input  logic [NumPorts-1:0]                 apb_pready_i,
  input  logic [NumPorts-1:0]                 apb_pslverr_i
);

  localparam int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned CntRaw   = $clog2(TimeoutCycles + 1);
  localparam int unsigned CntWidth = (CntRaw < 1) ? 1 : CntRaw;
  localparam logic [CntWidth-1:0] CntLast =
    (TimeoutCycles == 0) ? '0 : CntWidth'(TimeoutCycles - 1);

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q,  addr_d;
  logic                   we_q,    we_d;
  logic [BeWidth-1:0]     be_q,    be_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [IdxWidth-1:0]    idx_q,   idx_d;
  logic                   hit_q,   hit_d;
  logic [CntWidth-1:0]    cnt_q,   cnt_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   err_q,   err_d;

  logic [IdxWidth-1:0]    dec_idx;
  logic                   dec_hit;

  obi_apb_addr_decode #(
    .AddrWidth (AddrWidth),
    .NumPorts  (NumPorts),
    .IdxWidth  (IdxWidth),
    .BaseAddr  (BaseAddr),
    .AddrMask  (AddrMask)
  ) u_decode (
    .addr_i (obi_addr_i),
    .idx_o  (dec_idx),
    .hit_o  (dec_hit)
  );

  // A new request can be taken while the previous response is on the bus,
  // which is what gives the 3-cycle back-to-back throughput.
  assign obi_gnt_o = obi_req_i && ((state_q == IDLE) || (state_q == RESP));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) begin
          state_d = IDLE;
        end
        if (obi_gnt_o) begin
          addr_d  = obi_addr_i;
          we_d    = obi_we_i;
          be_d    = obi_be_i;
          wdata_d = obi_wdata_i;
          idx_d   = dec_idx;
          hit_d   = dec_hit;
          if (dec_hit) begin
            state_d = SETUP;
            cnt_d   = '0;
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            // Miss: answer immediately with an error, never touch APB.
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        cnt_d = cnt_q + CntWidth'(1);
        if (apb_pready_i[idx_q]) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : apb_prdata_i[idx_q];
          err_d   = apb_pslverr_i[idx_q];
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // APB side is driven purely from captured registers so it stays stable
  // for the whole SETUP/ACCESS window regardless of new OBI traffic.
  // hit_q also gates psel so a missed request can never select a port.
  always_comb begin
    apb_psel_o = '0;
    if (hit_q && ((state_q == SETUP) || (state_q == ACCESS))) begin
      apb_psel_o = NumPorts'(1) << idx_q;
    end
  end

  assign apb_penable_o = (state_q == ACCESS);
  assign apb_paddr_o   = addr_q;
  assign apb_pwrite_o  = we_q;
  assign apb_pwdata_o  = wdata_q;
  assign apb_pstrb_o   = we_q ? be_q : '0;
  assign apb_pprot_o   = Pprot;

  assign obi_rvalid_o  = (state_q == RESP);
  assign obi_rdata_o   = rdata_q;
  assign obi_err_o     = err_q;

endmodule

// File: tb/tb_obi_apb_bridge_mp.sv
// Directed self-checking bench for obi_apb_bridge_mp.
module tb_obi_apb_bridge_mp;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NP = 4;
  localparam int unsigned BW = DW / 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     obi_req;
  logic                     obi_gnt;
  logic [AW-1:0]            obi_addr;
  logic                     obi_we;
  logic [BW-1:0]            obi_be;
  logic [DW-1:0]            obi_wdata;
  logic                     obi_rvalid;
  logic [DW-1:0]            obi_rdata;
  logic                     obi_err;
  logic [AW-1:0]            paddr;
  logic                     pwrite;
  logic [DW-1:0]            pwdata;
  logic [BW-1:0]            pstrb;
  logic [2:0]               pprot;
  logic [NP-1:0]            psel;
  logic                     penable;
  logic [NP-1:0][DW-1:0]    prdata;
  logic [NP-1:0]            pready;
  logic [NP-1:0]            pslverr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obi_apb_bridge_mp #(
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .NumPorts      (NP),
    .BaseAddr      ({32'h1000_0300, 32'h1000_0200, 32'h1000_0100, 32'h1000_0000}),
    .AddrMask      ({4{32'hFFFF_FF00}}),
    .TimeoutCycles (4),
    .Pprot         (3'b010)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .obi_req_i     (obi_req),
    .obi_gnt_o     (obi_gnt),
    .obi_addr_i    (obi_addr),
    .obi_we_i      (obi_we),
    .obi_be_i      (obi_be),
    .obi_wdata_i   (obi_wdata),
    .obi_rvalid_o  (obi_rvalid),
    .obi_rdata_o   (obi_rdata),
    .obi_err_o     (obi_err),
    .apb_paddr_o   (paddr),
    .apb_pwrite_o  (pwrite),
    .apb_pwdata_o  (pwdata),
    .apb_pstrb_o   (pstrb),
    .apb_pprot_o   (pprot),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_prdata_i  (prdata),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr)
  );

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_read(input logic [AW-1:0] a);
    obi_req = 1'b1; obi_addr = a; obi_we = 1'b0; obi_be = 4'hF; obi_wdata = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (psel !== 4'b0000) begin failures++; $display("FAIL rst_psel got=%h exp=0", psel); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL rst_penable got=%b exp=0", penable); end
    checks++; if (obi_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", obi_rvalid); end
    checks++; if (obi_err !== 1'b0 || obi_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp got err=%b rdata=%h exp 0/0", obi_err, obi_rdata); end
    checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0) begin failures++; $display("FAIL rst_apb got paddr=%h pwdata=%h pstrb=%h exp 0", paddr, pwdata, pstrb); end
    checks++; if (pprot !== 3'b010) begin failures++; $display("FAIL pprot got=%b exp=010", pprot); end
    obi_req = 1'b1; #1;
    checks++; if (obi_gnt !== 1'b1) begin failures++; $display("FAIL rst_gnt_hi got=%b exp=1", obi_gnt); end
    obi_req = 1'b0; #1;
    checks++; if (obi_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt_lo got=%b exp=0", obi_gnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_zero_wait();
    pready = 4'b0010;
    req_read(32'h1000_0104);
    checks++; if (obi_gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt got=%b exp=1", obi_gnt); end
    step(); obi_req = 1'b0;
    checks++; if (psel !== 4'b0010 || penable !== 1'b0) begin failures++; $display("FAIL rd_setup got psel=%b pen=%b exp 0010/0", psel, penable); end
    checks++; if (paddr !== 32'h1000_0104 || pwrite !== 1'b0 || pstrb !== 4'h0) begin failures++; $display("FAIL rd_addr got paddr=%h pwrite=%b pstrb=%h", paddr, pwrite, pstrb); end
    step();
    checks++; if (psel !== 4'b0010 || penable !== 1'b1 || obi_rvalid !== 1'b0) begin failures++; $display("FAIL rd_access got psel=%b pen=%b rv=%b", psel, penable, obi_rvalid); end
    step();
    checks++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'hDEAD_BEEF || obi_err !== 1'b0) begin failures++; $display("FAIL rd_resp got rv=%b rdata=%h err=%b exp 1/deadbeef/0", obi_rvalid, obi_rdata, obi_err); end
    checks++; if (psel !== 4'b0000) begin failures++; $display("FAIL rd_resp_psel got=%b exp=0", psel); end
    step();
    checks++; if (obi_rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_once got=%b exp=0", obi_rvalid); end
    pready = '0;
  endtask

  task automatic test_write_waits();
    // Unselected port 0 shouts ready+error; the bridge must ignore it.
    pready = 4'b0001; pslverr = 4'b0001;
    obi_req = 1'b1; obi_addr = 32'h1000_0108; obi_we = 1'b1; obi_be = 4'b0011; obi_wdata = 32'hA5A5_5A5A;
    #1;
    checks++; if (obi_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", obi_gnt); end
    step(); obi_req = 1'b0; obi_wdata = '0; obi_addr = '0;
    checks++; if (psel !== 4'b0010 || pwrite !== 1'b1 || pstrb !== 4'b0011) begin failures++; $display("FAIL wr_setup got psel=%b pwrite=%b pstrb=%b", psel, pwrite, pstrb); end
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 2) pready[1] = 1'b1;
      checks++;
      if (penable !== 1'b1 || psel !== 4'b0010 || paddr !== 32'h1000_0108 || pwdata !== 32'hA5A5_5A5A || pstrb !== 4'b0011 || obi_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL wr_access%0d got pen=%b psel=%b paddr=%h pwdata=%h pstrb=%b rv=%b", k, penable, psel, paddr, pwdata, pstrb, obi_rvalid);
      end
    end
    step();
    checks++; if (obi_rvalid !== 1'b1 || obi_err !== 1'b0 || obi_rdata !== 32'h0) begin failures++; $display("FAIL wr_resp got rv=%b err=%b rdata=%h exp 1/0/0", obi_rvalid, obi_err, obi_rdata); end
    step();
    pready = '0; pslverr = '0;
  endtask

  task automatic test_miss();
    req_read(32'h2000_0000);
    checks++; if (obi_gnt !== 1'b1) begin failures++; $display("FAIL miss_gnt got=%b exp=1", obi_gnt); end
    step(); obi_req = 1'b0;
    checks++; if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || obi_rdata !== 32'h0) begin failures++; $display("FAIL miss_resp got rv=%b err=%b rdata=%h exp 1/1/0", obi_rvalid, obi_err, obi_rdata); end
    checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin failures++; $display("FAIL miss_psel got psel=%b pen=%b exp 0/0", psel, penable); end
    step();
  endtask

  task automatic test_timeout();
    int n_en = 0;
    bit got = 1'b0;
    pready = '0;
    req_read(32'h1000_0200);
    step(); obi_req = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (obi_rvalid) begin
        got = 1'b1;
        checks++; if (obi_err !== 1'b1 || obi_rdata !== 32'h0 || psel !== 4'b0000) begin failures++; $display("FAIL to_resp got err=%b rdata=%h psel=%b exp 1/0/0", obi_err, obi_rdata, psel); end
      end else if (penable) begin
        n_en++;
      end
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL to_rvalid got=%b exp=1", got); end
    checks++; if (n_en != 4) begin failures++; $display("FAIL to_penable_cycles got=%0d exp=4", n_en); end
    step();
    // The bridge must recover and serve port 0 normally.
    pready = 4'b0001;
    req_read(32'h1000_0004);
    step(); obi_req = 1'b0;
    step(); step();
    checks++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h1234_5678 || obi_err !== 1'b0) begin failures++; $display("FAIL to_recover got rv=%b rdata=%h err=%b exp 1/12345678/0", obi_rvalid, obi_rdata, obi_err); end
    step();
    pready = '0;
  endtask

  task automatic test_back_to_back();
    pready = 4'b1001; pslverr = 4'b1000;
    req_read(32'h1000_0304);
    step(); obi_req = 1'b0;
    step();
    step();
    checks++; if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || obi_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_first got rv=%b err=%b rdata=%h exp 1/1/cafef00d", obi_rvalid, obi_err, obi_rdata); end
    req_read(32'h1000_0010);
    checks++; if (obi_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt_in_resp got=%b exp=1", obi_gnt); end
    step(); obi_req = 1'b0;
    checks++; if (psel !== 4'b0001 || penable !== 1'b0 || obi_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_setup got psel=%b pen=%b rv=%b exp 0001/0/0", psel, penable, obi_rvalid); end
    step(); step();
    checks++; if (obi_rvalid !== 1'b1 || obi_err !== 1'b0 || obi_rdata !== 32'h1234_5678) begin failures++; $display("FAIL b2b_second got rv=%b err=%b rdata=%h exp 1/0/12345678", obi_rvalid, obi_err, obi_rdata); end
    step();
    pready = '0; pslverr = '0;
  endtask

  task automatic test_reset_access();
    int rv_seen = 0;
    pready = '0;
    req_read(32'h1000_0100);
    step(); obi_req = 1'b0;
    step();
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL ra_in_access got pen=%b exp=1", penable); end
    rst = 1'b1;
    step(); rst = 1'b0;
    checks++; if (psel !== 4'b0000 || penable !== 1'b0 || obi_rvalid !== 1'b0) begin failures++; $display("FAIL ra_after_rst got psel=%b pen=%b rv=%b exp 0/0/0", psel, penable, obi_rvalid); end
    pready = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      if (obi_rvalid) rv_seen++;
    end
    checks++; if (rv_seen != 0) begin failures++; $display("FAIL ra_no_rvalid got=%0d exp=0", rv_seen); end
    pready = '0;
  endtask

  initial begin
    rst = 1'b1; obi_req = 1'b0; obi_addr = '0; obi_we = 1'b0; obi_be = '0; obi_wdata = '0;
    pready = '0; pslverr = '0;
    prdata = {32'hCAFE_F00D, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h1234_5678};
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_miss();
    test_timeout();
    test_back_to_back();
    test_reset_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
